// File: rtl/chord_song_reader.sv
// chord_song_reader
//
// Sequencer that walks one song in an external synchronous song ROM and feeds
// the three-voice note player with note-load commands. Consecutive note
// entries form a chord; wait entries insert a beat-timed pause; a wait entry
// with zero duration marks the end of the song.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high; returns the block to IDLE
//   play        level: 1 = run, 0 = pause (all state frozen)
//   song        song select, latched when leaving IDLE
//   beat        one-cycle beat tick (48 Hz)
//   voice_free  note player can accept a load this cycle
//   rom_addr    registered ROM address {song_latched, index}
//   rom_data    ROM word, captured at the end of the second FETCH cycle
//   new_note    one-cycle load strobe to the note player
//   note        note to load, held until the next note entry is decoded
//   duration    duration in beats, held until the next note entry is decoded
//   advance     note-player counter enable
//   song_done   one-cycle pulse on entering DONE
//
// ROM word: [15] is_wait, [14:9] note, [8:3] duration, [2:0] reserved.

module chord_song_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic [1:0]  song,
  input  logic        beat,
  input  logic        voice_free,
  output logic [6:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        new_note,
  output logic [5:0]  note,
  output logic [5:0]  duration,
  output logic        advance,
  output logic        song_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_LOAD   = 3'd3,
    S_WAIT   = 3'd4,
    S_NEXT   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // Captured word keeps only the meaningful fields: {is_wait, note, duration}.
  function automatic logic word_is_wait(input logic [12:0] w);
    return w[12];
  endfunction

  function automatic logic [5:0] word_note(input logic [12:0] w);
    return w[11:6];
  endfunction

  function automatic logic [5:0] word_duration(input logic [12:0] w);
    return w[5:0];
  endfunction

  state_t      state_r, state_s;
  logic [1:0]  song_r, song_s;
  logic [4:0]  index_r, index_s;
  logic        fetch_cnt_r, fetch_cnt_s;
  logic [12:0] word_r, word_s;
  logic [5:0]  beat_cnt_r, beat_cnt_s;
  logic [5:0]  note_r, note_s;
  logic [5:0]  duration_r, duration_s;
  logic        advance_r;
  logic        song_done_r;
  logic        load_s;

  // Reserved ROM bits carry no meaning and are dropped on capture.
  logic        rsvd_unused_s;
  assign rsvd_unused_s = ^rom_data[2:0];

  // Next-state, datapath updates and the load strobe.
  always_comb begin
    state_s     = state_r;
    song_s      = song_r;
    index_s     = index_r;
    fetch_cnt_s = fetch_cnt_r;
    word_s      = word_r;
    beat_cnt_s  = beat_cnt_r;
    note_s      = note_r;
    duration_s  = duration_r;
    load_s      = 1'b0;

    if ((state_r != S_IDLE) && (song != song_r)) begin
      // A new song selection abandons the current one, even while paused.
      state_s = S_IDLE;
    end else if (play) begin
      case (state_r)
        S_IDLE: begin
          song_s      = song;
          index_s     = 5'd0;
          fetch_cnt_s = 1'b0;
          state_s     = S_FETCH;
        end
        S_FETCH: begin
          // Two-cycle fetch: the ROM word is stable by the second cycle.
          if (fetch_cnt_r == 1'b0) begin
            fetch_cnt_s = 1'b1;
          end else begin
            fetch_cnt_s = 1'b0;
            word_s      = rom_data[15:3];
            state_s     = S_DECODE;
          end
        end
        S_DECODE: begin
          if (!word_is_wait(word_r)) begin
            // note/duration are loaded here so they are already valid
            // during the LOAD cycle and stay put after the strobe.
            note_s     = word_note(word_r);
            duration_s = word_duration(word_r);
            state_s    = S_LOAD;
          end else if (word_duration(word_r) == 6'd0) begin
            state_s = S_DONE;
          end else begin
            // A beat in this cycle is deliberately not counted.
            beat_cnt_s = word_duration(word_r);
            state_s    = S_WAIT;
          end
        end
        S_LOAD: begin
          if (voice_free) begin
            load_s  = 1'b1;
            state_s = S_NEXT;
          end else begin
            state_s = S_LOAD;
          end
        end
        S_WAIT: begin
          if (beat) begin
            if (beat_cnt_r <= 6'd1) begin
              beat_cnt_s = 6'd0;
              state_s    = S_NEXT;
            end else begin
              beat_cnt_s = beat_cnt_r - 6'd1;
            end
          end else begin
            beat_cnt_s = beat_cnt_r;
          end
        end
        S_NEXT: begin
          // No wrap: the last slot of a song terminates it.
          if (index_r == 5'd31) begin
            state_s = S_DONE;
          end else begin
            index_s     = index_r + 5'd1;
            fetch_cnt_s = 1'b0;
            state_s     = S_FETCH;
          end
        end
        S_DONE: begin
          state_s = S_DONE;
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end else begin
      // Paused: everything holds.
      state_s = state_r;
    end
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      song_r      <= 2'd0;
      index_r     <= 5'd0;
      fetch_cnt_r <= 1'b0;
      word_r      <= 13'd0;
      beat_cnt_r  <= 6'd0;
      note_r      <= 6'd0;
      duration_r  <= 6'd0;
      advance_r   <= 1'b0;
      song_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      song_r      <= song_s;
      index_r     <= index_s;
      fetch_cnt_r <= fetch_cnt_s;
      word_r      <= word_s;
      beat_cnt_r  <= beat_cnt_s;
      note_r      <= note_s;
      duration_r  <= duration_s;
      // Registered from the next state so advance rises with the first FETCH.
      advance_r   <= play & (state_s != S_IDLE) & (state_s != S_DONE);
      song_done_r <= (state_s == S_DONE) & (state_r != S_DONE);
    end
  end

  assign rom_addr  = {song_r, index_r};
  // The strobe must answer voice_free in the same cycle, so it is decoded
  // straight from the state register; reset clears it asynchronously.
  assign new_note  = load_s;
  assign note      = note_r;
  assign duration  = duration_r;
  assign advance   = advance_r;
  assign song_done = song_done_r;

endmodule

// File: tb/tb_chord_song_reader.sv
// tb_chord_song_reader
//
// Directed bench for chord_song_reader with a one-register synchronous ROM
// model. Each task drives one scenario cycle by cycle and checks outputs
// against hand-derived cycle offsets.

module tb_chord_song_reader;

  logic        clk;
  logic        reset;
  logic        play;
  logic [1:0]  song;
  logic        beat;
  logic        voice_free;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data;
  logic        new_note;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        advance;
  logic        song_done;

  int total;
  int bad;

  logic [15:0] rom [0:127];

  chord_song_reader dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .song       (song),
    .beat       (beat),
    .voice_free (voice_free),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .new_note   (new_note),
    .note       (note),
    .duration   (duration),
    .advance    (advance),
    .song_done  (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: word for rom_addr appears one edge later.
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [15:0] mk(input logic w, input logic [5:0] n, input logic [5:0] d);
    return {w, n, d, 3'b000};
  endfunction

  // Advance one cycle and apply this cycle's inputs; returns at the sample point.
  task automatic cyc(input logic p, input logic [1:0] s, input logic vf, input logic bt);
    @(posedge clk);
    #1;
    play = p;
    song = s;
    voice_free = vf;
    beat = bt;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    play = 1'b0;
    song = 2'd0;
    beat = 1'b0;
    voice_free = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total = total + 6;
    if (rom_addr !== 7'd0) begin bad = bad + 1; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
    if (new_note !== 1'b0) begin bad = bad + 1; $display("FAIL reset_new_note: got %0b expected 0", new_note); end
    if (note !== 6'd0) begin bad = bad + 1; $display("FAIL reset_note: got %0d expected 0", note); end
    if (duration !== 6'd0) begin bad = bad + 1; $display("FAIL reset_duration: got %0d expected 0", duration); end
    if (advance !== 1'b0) begin bad = bad + 1; $display("FAIL reset_advance: got %0b expected 0", advance); end
    if (song_done !== 1'b0) begin bad = bad + 1; $display("FAIL reset_song_done: got %0b expected 0", song_done); end
    reset = 1'b0;
  endtask

  // Song 2: play rises at cycle 0, load of ROM[64] at cycle 4, marker at 65.
  task automatic test_start();
    for (int k = 0; k <= 11; k++) begin
      cyc(1'b1, 2'd2, 1'b1, 1'b0);
      total = total + 1;
      if (new_note !== (k == 4)) begin bad = bad + 1; $display("FAIL start_new_note k=%0d: got %0b expected %0b", k, new_note, (k == 4)); end
      if (k == 0) begin
        total = total + 1;
        if (advance !== 1'b0) begin bad = bad + 1; $display("FAIL start_advance0: got %0b expected 0", advance); end
      end
      if (k == 1) begin
        total = total + 2;
        if (rom_addr !== 7'd64) begin bad = bad + 1; $display("FAIL start_rom_addr: got %0d expected 64", rom_addr); end
        if (advance !== 1'b1) begin bad = bad + 1; $display("FAIL start_advance1: got %0b expected 1", advance); end
      end
      if (k == 3) begin
        total = total + 1;
        if (note !== 6'd0) begin bad = bad + 1; $display("FAIL start_note_early: got %0d expected 0", note); end
      end
      if (k == 4) begin
        total = total + 2;
        if (note !== 6'd20) begin bad = bad + 1; $display("FAIL start_note: got %0d expected 20", note); end
        if (duration !== 6'd12) begin bad = bad + 1; $display("FAIL start_duration: got %0d expected 12", duration); end
      end
      if (k >= 5) begin
        total = total + 1;
        if (song_done !== (k == 9)) begin bad = bad + 1; $display("FAIL start_song_done k=%0d: got %0b expected %0b", k, song_done, (k == 9)); end
      end
    end
  endtask

  // Song 0: chord 10/14/17, wait 3 beats, backpressured load of 30, end marker.
  task automatic test_chord_wait_backpressure_end();
    logic vf;
    logic bt;
    logic exp_nn;
    for (int k = 0; k <= 60; k++) begin
      vf = !((k >= 31) && (k <= 52));
      bt = (k == 19) || (k == 22) || (k == 25) || (k == 28);
      cyc(1'b1, 2'd0, vf, bt);
      if (k >= 1) begin
        exp_nn = (k == 5) || (k == 10) || (k == 15) || (k == 53);
        total = total + 1;
        if (new_note !== exp_nn) begin bad = bad + 1; $display("FAIL chord_new_note k=%0d: got %0b expected %0b", k, new_note, exp_nn); end
      end
      case (k)
        2: begin
          total = total + 1;
          if (rom_addr !== 7'd0) begin bad = bad + 1; $display("FAIL chord_rom_addr0: got %0d expected 0", rom_addr); end
        end
        5, 10, 15: begin
          total = total + 2;
          if (note !== ((k == 5) ? 6'd10 : (k == 10) ? 6'd14 : 6'd17)) begin bad = bad + 1; $display("FAIL chord_note k=%0d: got %0d", k, note); end
          if (duration !== 6'd24) begin bad = bad + 1; $display("FAIL chord_duration k=%0d: got %0d expected 24", k, duration); end
        end
        29: begin
          total = total + 1;
          if (rom_addr !== 7'd3) begin bad = bad + 1; $display("FAIL wait_rom_addr_hold: got %0d expected 3", rom_addr); end
        end
        30: begin
          total = total + 1;
          if (rom_addr !== 7'd4) begin bad = bad + 1; $display("FAIL wait_rom_addr_next: got %0d expected 4", rom_addr); end
        end
        53: begin
          total = total + 2;
          if (note !== 6'd30) begin bad = bad + 1; $display("FAIL bp_note: got %0d expected 30", note); end
          if (duration !== 6'd5) begin bad = bad + 1; $display("FAIL bp_duration: got %0d expected 5", duration); end
        end
        58: begin
          total = total + 3;
          if (song_done !== 1'b1) begin bad = bad + 1; $display("FAIL end_song_done: got %0b expected 1", song_done); end
          if (advance !== 1'b0) begin bad = bad + 1; $display("FAIL end_advance: got %0b expected 0", advance); end
          if (rom_addr !== 7'd5) begin bad = bad + 1; $display("FAIL end_rom_addr: got %0d expected 5", rom_addr); end
        end
        59, 60: begin
          total = total + 2;
          if (song_done !== 1'b0) begin bad = bad + 1; $display("FAIL end_song_done_once k=%0d: got %0b expected 0", k, song_done); end
          if (rom_addr !== 7'd5) begin bad = bad + 1; $display("FAIL end_rom_addr_held k=%0d: got %0d expected 5", k, rom_addr); end
        end
        default: begin
        end
      endcase
    end
  endtask

  // Song 3: 32 note entries and no marker; DONE after index 31.
  task automatic test_no_marker();
    logic exp_nn;
    int loads;
    loads = 0;
    for (int k = 0; k <= 165; k++) begin
      cyc(1'b1, 2'd3, 1'b1, 1'b0);
      if (k >= 1) begin
        exp_nn = (k >= 5) && (k <= 160) && ((k % 5) == 0);
        total = total + 2;
        if (new_note !== exp_nn) begin bad = bad + 1; $display("FAIL nomark_new_note k=%0d: got %0b expected %0b", k, new_note, exp_nn); end
        if (song_done !== (k == 162)) begin bad = bad + 1; $display("FAIL nomark_song_done k=%0d: got %0b expected %0b", k, song_done, (k == 162)); end
        if (exp_nn) begin
          loads = loads + 1;
          total = total + 2;
          if (note !== 6'(k / 5)) begin bad = bad + 1; $display("FAIL nomark_note k=%0d: got %0d expected %0d", k, note, k / 5); end
          if (duration !== 6'(41 - (k / 5))) begin bad = bad + 1; $display("FAIL nomark_duration k=%0d: got %0d expected %0d", k, duration, 41 - (k / 5)); end
        end
      end
      if (k == 162) begin
        total = total + 1;
        if (rom_addr !== 7'd127) begin bad = bad + 1; $display("FAIL nomark_rom_addr: got %0d expected 127", rom_addr); end
      end
    end
    total = total + 1;
    if (loads != 32) begin bad = bad + 1; $display("FAIL nomark_load_count: got %0d expected 32", loads); end
  endtask

  // Song 0 into its wait, switch to song 1, pause mid-wait, then reset in LOAD.
  task automatic test_song_change_pause_reset();
    logic p;
    logic vf;
    logic bt;
    logic exp_nn;
    for (int k = 0; k <= 59; k++) begin
      p  = !((k >= 36) && (k <= 46));
      vf = (k < 55);
      bt = (k == 33) || (k == 35) || (k == 37) || (k == 39) || (k == 41) ||
           (k == 43) || (k == 45) || (k == 49) || (k == 53);
      cyc(p, (k >= 22) ? 2'd1 : 2'd0, vf, bt);
      if (k >= 1) begin
        exp_nn = (k == 5) || (k == 10) || (k == 15) || (k == 27);
        total = total + 1;
        if (new_note !== exp_nn) begin bad = bad + 1; $display("FAIL sc_new_note k=%0d: got %0b expected %0b", k, new_note, exp_nn); end
      end
      case (k)
        23: begin
          total = total + 1;
          if (advance !== 1'b0) begin bad = bad + 1; $display("FAIL sc_idle_advance: got %0b expected 0", advance); end
        end
        24: begin
          total = total + 1;
          if (rom_addr !== 7'd32) begin bad = bad + 1; $display("FAIL sc_rom_addr: got %0d expected 32", rom_addr); end
        end
        27: begin
          total = total + 2;
          if (note !== 6'd40) begin bad = bad + 1; $display("FAIL sc_note: got %0d expected 40", note); end
          if (duration !== 6'd7) begin bad = bad + 1; $display("FAIL sc_duration: got %0d expected 7", duration); end
        end
        38: begin
          total = total + 1;
          if (advance !== 1'b0) begin bad = bad + 1; $display("FAIL pause_advance: got %0b expected 0", advance); end
        end
        50, 51, 52, 53, 54: begin
          total = total + 1;
          if (rom_addr !== 7'd33) begin bad = bad + 1; $display("FAIL pause_rom_addr_hold k=%0d: got %0d expected 33", k, rom_addr); end
        end
        55: begin
          total = total + 1;
          if (rom_addr !== 7'd34) begin bad = bad + 1; $display("FAIL pause_rom_addr_next: got %0d expected 34", rom_addr); end
        end
        58: begin
          total = total + 2;
          if (note !== 6'd50) begin bad = bad + 1; $display("FAIL rst_pre_note: got %0d expected 50", note); end
          if (advance !== 1'b1) begin bad = bad + 1; $display("FAIL rst_pre_advance: got %0b expected 1", advance); end
        end
        default: begin
        end
      endcase
    end
    // Mid-cycle reset while in LOAD, with voice_free rising alongside.
    reset = 1'b1;
    voice_free = 1'b1;
    #1;
    total = total + 6;
    if (rom_addr !== 7'd0) begin bad = bad + 1; $display("FAIL rst_rom_addr: got %0d expected 0", rom_addr); end
    if (new_note !== 1'b0) begin bad = bad + 1; $display("FAIL rst_new_note: got %0b expected 0", new_note); end
    if (note !== 6'd0) begin bad = bad + 1; $display("FAIL rst_note: got %0d expected 0", note); end
    if (duration !== 6'd0) begin bad = bad + 1; $display("FAIL rst_duration: got %0d expected 0", duration); end
    if (advance !== 1'b0) begin bad = bad + 1; $display("FAIL rst_advance: got %0b expected 0", advance); end
    if (song_done !== 1'b0) begin bad = bad + 1; $display("FAIL rst_song_done: got %0b expected 0", song_done); end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      total = total + 1;
      if (new_note !== 1'b0) begin bad = bad + 1; $display("FAIL rst_hold_new_note k=%0d: got %0b expected 0", k, new_note); end
    end
    reset = 1'b0;
    play = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 128; i++) rom[i] = mk(1'b1, 6'd0, 6'd0);
    rom[0]  = mk(1'b0, 6'd10, 6'd24);
    rom[1]  = mk(1'b0, 6'd14, 6'd24);
    rom[2]  = mk(1'b0, 6'd17, 6'd24);
    rom[3]  = mk(1'b1, 6'd0,  6'd3);
    rom[4]  = mk(1'b0, 6'd30, 6'd5);
    rom[5]  = mk(1'b1, 6'd0,  6'd0);
    rom[32] = mk(1'b0, 6'd40, 6'd7);
    rom[33] = mk(1'b1, 6'd0,  6'd4);
    rom[34] = mk(1'b0, 6'd50, 6'd9);
    rom[35] = mk(1'b1, 6'd0,  6'd0);
    rom[64] = mk(1'b0, 6'd20, 6'd12);
    for (int i = 0; i < 32; i++) rom[96 + i] = mk(1'b0, 6'(i + 1), 6'(40 - i));

    test_reset();
    test_start();
    test_chord_wait_backpressure_end();
    test_no_marker();
    test_song_change_pause_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
